// File: rtl/sig_decode_pwm.sv
// Pulse-width symbol decoder with word assembly, gap timeout and framing-error reporting.
// Latency: symbol strobe SPS cycles after its rising edge; the word strobe coincides with its last symbol.
// Backpressure: none; every output is a one-cycle strobe the consumer must take when it appears.
module sig_decode_pwm #(
  parameter int SPS       = 4,
  parameter int ONE_MIN   = 3,
  parameter int ZERO_MAX  = 1,
  parameter int WORD_BITS = 8,
  parameter int GAP_MAX   = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 Data_In,
  output logic [1:0]           Sym_Code,
  output logic                 Sym_Valid,
  output logic [WORD_BITS-1:0] Word_Out,
  output logic                 Word_Valid,
  output logic                 Frame_Err,
  output logic                 Busy
);

  localparam int CW = $clog2(SPS + 1);
  localparam int BW = $clog2(WORD_BITS + 1);
  localparam int GW = $clog2(GAP_MAX + 1);

  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_ZERO = 2'b10;
  localparam logic [1:0] CODE_ERR  = 2'b11;

  typedef enum logic {IDLE, SAMPLE} state_t;

  state_t               state, state_nxt;
  logic                 prev;
  logic [CW-1:0]        ones, smp;
  logic [CW-1:0]        ones_nxt, smp_nxt;
  logic [BW-1:0]        bitcnt;
  logic [GW-1:0]        gapcnt;
  logic [WORD_BITS-1:0] shreg, word_nxt;
  logic [1:0]           code_nxt;
  logic                 rise, start, sym_done, abort, sym_bit, word_done, gap_wait, gap_hit;

  always_comb begin
    rise      = Data_In & ~prev;
    start     = (state == IDLE) & Enable & rise;
    ones_nxt  = ones + CW'(Data_In);
    smp_nxt   = smp + CW'(1);
    sym_done  = (state == SAMPLE) & Enable & (smp_nxt == CW'(SPS));
    abort     = (state == SAMPLE) & ~Enable;
    if (ones_nxt >= CW'(ONE_MIN))
      code_nxt = CODE_ONE;
    else if (ones_nxt <= CW'(ZERO_MAX))
      code_nxt = CODE_ZERO;
    else
      code_nxt = CODE_ERR;
    sym_bit   = (code_nxt == CODE_ONE);
    word_nxt  = (shreg << 1) | WORD_BITS'(sym_bit);
    word_done = (bitcnt == BW'(WORD_BITS - 1));
    // A rise that starts a new symbol always beats an expiring gap timer.
    gap_wait  = (state == IDLE) & ~start & (bitcnt != '0);
    gap_hit   = gap_wait & (gapcnt == GW'(GAP_MAX - 1));
  end

  always_ff @(posedge clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SAMPLE;
      SAMPLE:  if (abort || sym_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == SAMPLE) | (bitcnt != '0);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      prev       <= 1'b0;
      ones       <= '0;
      smp        <= '0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      shreg      <= '0;
      Word_Out   <= '0;
      Sym_Code   <= 2'b00;
      Sym_Valid  <= 1'b0;
      Word_Valid <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      prev       <= Data_In;
      Sym_Code   <= 2'b00;
      Sym_Valid  <= 1'b0;
      Word_Valid <= 1'b0;
      Frame_Err  <= 1'b0;

      if (start) begin
        ones   <= CW'(1);
        smp    <= CW'(1);
        gapcnt <= '0;
      end else if (state == SAMPLE) begin
        ones <= ones_nxt;
        smp  <= smp_nxt;
      end

      // Aborted symbols drop the partial word without any strobe.
      if (abort)
        bitcnt <= '0;

      if (sym_done) begin
        Sym_Valid <= 1'b1;
        Sym_Code  <= code_nxt;
        if (code_nxt == CODE_ERR) begin
          Frame_Err <= 1'b1;
          bitcnt    <= '0;
        end else if (word_done) begin
          shreg      <= word_nxt;
          Word_Out   <= word_nxt;
          Word_Valid <= 1'b1;
          bitcnt     <= '0;
        end else begin
          shreg  <= word_nxt;
          bitcnt <= bitcnt + BW'(1);
        end
      end

      if (gap_hit) begin
        Frame_Err <= 1'b1;
        bitcnt    <= '0;
        gapcnt    <= '0;
      end else if (gap_wait) begin
        gapcnt <= gapcnt + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sig_decode_pwm.sv
// Scoreboard bench: expected symbol/word/frame-error strobes are queued with their due cycle
// when stimulus is driven, and popped when the decoder raises the matching strobe.
module tb_sig_decode_pwm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset;
  logic       en0, din0, en1, din1;
  logic [1:0] code0, code1;
  logic       sv0, sv1, wv0, wv1, fe0, fe1, busy0, busy1;
  logic [7:0] word0;
  logic [3:0] word1;

  sig_decode_pwm dut0 (
    .clk(clk), .Reset(Reset), .Enable(en0), .Data_In(din0),
    .Sym_Code(code0), .Sym_Valid(sv0), .Word_Out(word0), .Word_Valid(wv0),
    .Frame_Err(fe0), .Busy(busy0)
  );

  sig_decode_pwm #(.SPS(8), .ONE_MIN(6), .ZERO_MAX(2), .WORD_BITS(4), .GAP_MAX(16)) dut1 (
    .clk(clk), .Reset(Reset), .Enable(en1), .Data_In(din1),
    .Sym_Code(code1), .Sym_Valid(sv1), .Word_Out(word1), .Word_Valid(wv1),
    .Frame_Err(fe1), .Busy(busy1)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t sq0[$], wq0[$], fq0[$], sq1[$], wq1[$], fq1[$];
  ev_t e0, e1;
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  last_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // kind: 0 = symbol, 1 = word, 2 = frame error
  task automatic push(input int u, input int kind, input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    if (u == 0) begin
      if (kind == 0) sq0.push_back(e);
      else if (kind == 1) wq0.push_back(e);
      else fq0.push_back(e);
    end else begin
      if (kind == 0) sq1.push_back(e);
      else if (kind == 1) wq1.push_back(e);
      else fq1.push_back(e);
    end
  endtask

  task automatic drive(input int u, input logic b);
    if (u == 0) din0 = b;
    else din1 = b;
  endtask

  task automatic send_sym(input int u, input logic [7:0] pat, input int code, input bit err);
    int sps = (u == 0) ? 4 : 8;
    for (int k = 0; k < sps; k++) begin
      @(negedge clk);
      if (k == 0) begin
        last_d = cyc;
        push(u, 0, cyc + sps, code);
        if (err) push(u, 2, cyc + sps, 0);
      end
      drive(u, pat[sps-1-k]);
    end
  endtask

  task automatic send_word(input int u, input logic [7:0] w, input int nb);
    logic [7:0] one_p  = (u == 0) ? 8'h0E : 8'hFC;
    logic [7:0] zero_p = (u == 0) ? 8'h08 : 8'hC0;
    int         sps    = (u == 0) ? 4 : 8;
    for (int i = nb - 1; i >= 0; i--) begin
      if (w[i]) send_sym(u, one_p, 1, 1'b0);
      else send_sym(u, zero_p, 2, 1'b0);
    end
    push(u, 1, last_d + sps, int'(w));
  endtask

  task automatic idle(input int u, input int n);
    repeat (n) begin
      @(negedge clk);
      drive(u, 1'b0);
    end
  endtask

  task automatic idle_until(input int u, input int target);
    while (cyc < target) begin
      @(negedge clk);
      drive(u, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (sv0) begin
      if (sq0.size() == 0) check("sym0_spurious", 32'(sv0), 0);
      else begin
        e0 = sq0.pop_front();
        check("sym0_cycle", cyc, e0.cyc);
        check("sym0_code", 32'(code0), e0.val);
      end
    end
    if (wv0) begin
      if (wq0.size() == 0) check("word0_spurious", 32'(wv0), 0);
      else begin
        e0 = wq0.pop_front();
        check("word0_cycle", cyc, e0.cyc);
        check("word0_value", 32'(word0), e0.val);
      end
    end
    if (fe0) begin
      if (fq0.size() == 0) check("ferr0_spurious", 32'(fe0), 0);
      else begin
        e0 = fq0.pop_front();
        check("ferr0_cycle", cyc, e0.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (sv1) begin
      if (sq1.size() == 0) check("sym1_spurious", 32'(sv1), 0);
      else begin
        e1 = sq1.pop_front();
        check("sym1_cycle", cyc, e1.cyc);
        check("sym1_code", 32'(code1), e1.val);
      end
    end
    if (wv1) begin
      if (wq1.size() == 0) check("word1_spurious", 32'(wv1), 0);
      else begin
        e1 = wq1.pop_front();
        check("word1_cycle", cyc, e1.cyc);
        check("word1_value", 32'(word1), e1.val);
      end
    end
    if (fe1) begin
      if (fq1.size() == 0) check("ferr1_spurious", 32'(fe1), 0);
      else begin
        e1 = fq1.pop_front();
        check("ferr1_cycle", cyc, e1.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, s;
    Reset = 1'b1;
    en0 = 1'b0; din0 = 1'b0;
    en1 = 1'b0; din1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code", 32'(code0), 0);
    check("rst_symv", 32'(sv0), 0);
    check("rst_word", 32'(word0), 0);
    check("rst_wordv", 32'(wv0), 0);
    check("rst_ferr", 32'(fe0), 0);
    check("rst_busy", 32'(busy0), 0);
    Reset = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;
    idle(0, 3);

    // single symbol 0,1,1,1,0; the lone bit then times out
    @(negedge clk);
    check("t1_busy_pre", 32'(busy0), 0);
    d = cyc;
    din0 = 1'b1;
    push(0, 0, d + 4, 1);
    push(0, 2, d + 4 + 16, 0);
    @(negedge clk);
    check("t1_busy", 32'(busy0), 1);
    din0 = 1'b1;
    @(negedge clk) din0 = 1'b1;
    @(negedge clk) din0 = 1'b0;
    idle_until(0, d + 24);

    // back-to-back word
    send_word(0, 8'hB2, 8);
    idle(0, 3);
    check("t2_busy_after", 32'(busy0), 0);
    check("t2_word_hold", 32'(word0), 32'hB2);

    // symbol error drops partial word
    send_sym(0, 8'h0E, 1, 1'b0);
    send_sym(0, 8'h08, 2, 1'b0);
    send_sym(0, 8'h0C, 3, 1'b1);
    send_word(0, 8'h5A, 8);
    idle(0, 3);
    check("t3_word_hold", 32'(word0), 32'h5A);

    // gap timeout after three bits
    send_sym(0, 8'h0E, 1, 1'b0);
    send_sym(0, 8'h08, 2, 1'b0);
    send_sym(0, 8'h0E, 1, 1'b0);
    s = last_d + 4;
    push(0, 2, s + 16, 0);
    idle_until(0, s + 15);
    check("t4_busy_before_to", 32'(busy0), 1);
    idle_until(0, s + 17);
    check("t4_busy_after_to", 32'(busy0), 0);

    // line held high: one 1111 symbol, then masked, then its lone bit times out
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        d = cyc;
        push(0, 0, d + 4, 1);
        push(0, 2, d + 4 + 16, 0);
      end
      din0 = 1'b1;
    end
    idle_until(0, d + 24);

    // Enable dropped at sample 2 after two bits
    send_sym(0, 8'h0E, 1, 1'b0);
    send_sym(0, 8'h0E, 1, 1'b0);
    @(negedge clk);
    din0 = 1'b1;
    @(negedge clk) din0 = 1'b1;
    @(negedge clk) begin en0 = 1'b0; din0 = 1'b1; end
    @(negedge clk) din0 = 1'b0;
    @(negedge clk);
    check("t5_busy_abort", 32'(busy0), 0);
    en0 = 1'b1;
    idle(0, 24);
    send_word(0, 8'hC3, 8);
    idle(0, 3);
    check("t5_word_hold", 32'(word0), 32'hC3);

    // reset mid-word, mid-symbol
    send_sym(0, 8'h0E, 1, 1'b0);
    send_sym(0, 8'h08, 2, 1'b0);
    send_sym(0, 8'h0E, 1, 1'b0);
    @(negedge clk) din0 = 1'b1;
    @(negedge clk) begin Reset = 1'b1; din0 = 1'b0; end
    @(negedge clk);
    Reset = 1'b0;
    check("t5_rst_code", 32'(code0), 0);
    check("t5_rst_symv", 32'(sv0), 0);
    check("t5_rst_word", 32'(word0), 0);
    check("t5_rst_wordv", 32'(wv0), 0);
    check("t5_rst_ferr", 32'(fe0), 0);
    check("t5_rst_busy", 32'(busy0), 0);
    idle(0, 3);
    send_word(0, 8'h3C, 8);
    idle(0, 3);
    check("t5_word_after_rst", 32'(word0), 32'h3C);

    // wide-symbol instance
    send_sym(1, 8'hF0, 3, 1'b1);
    send_word(1, 8'h09, 4);
    idle(1, 5);
    check("t6_word_hold", 32'(word1), 32'h9);
    check("t6_busy_after", 32'(busy1), 0);
    send_word(1, 8'h06, 4);
    idle(1, 20);

    check("left_sym0", sq0.size(), 0);
    check("left_word0", wq0.size(), 0);
    check("left_ferr0", fq0.size(), 0);
    check("left_sym1", sq1.size(), 0);
    check("left_word1", wq1.size(), 0);
    check("left_ferr1", fq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
